// File: rtl/matmul_seq_engine_if.sv
// Scratchpad read/write port bundle between matmul_seq_engine (master) and the scratchpad (slave).
// Signal suffixes are named from the engine's point of view.
interface matmul_seq_engine_if #(
   parameter int BUS_WIDTH  = 16,
   parameter int ADDR_WIDTH = 32
);
   logic                  rd_en_o;
   logic [ADDR_WIDTH-1:0] rd_addr_o;
   logic [BUS_WIDTH-1:0]  rd_data_i;
   logic                  wr_en_o;
   logic [ADDR_WIDTH-1:0] wr_addr_o;
   logic [BUS_WIDTH-1:0]  wr_data_o;

   modport master (
      output rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
      input  rd_data_i
   );

   modport slave (
      input  rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
      output rd_data_i
   );
endinterface

// File: rtl/matmul_seq_engine.sv
// Self-sequencing signed matrix engine: loads A, B and optional bias C from the scratchpad,
// computes C_out = A*B (+C) on one time-multiplexed MAC and writes saturated results back.
module matmul_seq_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 16,
   parameter int ADDR_WIDTH = 32,
   localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
   localparam int DIM_W     = $clog2(MAX_DIM) + 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       mode_i,
   input  logic [DIM_W-1:0]           n_dim_i,
   input  logic [DIM_W-1:0]           k_dim_i,
   input  logic [DIM_W-1:0]           m_dim_i,
   matmul_seq_engine_if.master        bus,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o,
   output logic [MAX_DIM*MAX_DIM-1:0] flags_o
);
   localparam int IW    = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
   localparam int EW    = 2 * IW;
   localparam int NE    = MAX_DIM * MAX_DIM;
   localparam int ACC_W = 2 * DATA_WIDTH + $clog2(MAX_DIM) + 1;
   localparam logic [DIM_W-1:0] DMAX  = DIM_W'(MAX_DIM);
   localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);
   localparam logic [4:0] SEL_A = 5'b00100, SEL_B = 5'b01000, SEL_C = 5'b10000;

   typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_C,
                             S_DRAIN, S_COMPUTE, S_WRITE, S_DONE} state_t;
   typedef enum logic [1:0] {T_NONE, T_A, T_B, T_C} tag_t;

   state_t state_q, state_d;
   tag_t   tag_q, tag_d;
   logic [EW-1:0]    tidx_q, tidx_d;
   logic [DIM_W-1:0] n_q, n_d, k_q, k_d, m_q, m_d;
   logic [DIM_W-1:0] cnt_q, cnt_d, i_q, i_d, j_q, j_d, l_q, l_d;
   logic             mode_q, mode_d, err_q, err_d;
   logic [NE-1:0]    flags_q, flags_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;

   logic signed [DATA_WIDTH-1:0] a_q [MAX_DIM][MAX_DIM];
   logic signed [DATA_WIDTH-1:0] b_q [MAX_DIM][MAX_DIM];
   logic signed [BUS_WIDTH-1:0]  c_q [NE];
   logic signed [BUS_WIDTH-1:0]  res_q [NE];

   function automatic logic [ADDR_WIDTH-1:0] mk_addr(input logic [4:0] sel, input logic [EW-1:0] idx);
      logic [ADDR_WIDTH-1:0] a;
      a = '0;
      a[4:0] = sel;
      a[5 +: EW] = idx;
      return a;
   endfunction

   // Returns {clamped flag, clamped value}.
   function automatic logic [BUS_WIDTH:0] saturate(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] hi, lo;
      hi = {{(ACC_W-BUS_WIDTH+1){1'b0}}, {(BUS_WIDTH-1){1'b1}}};
      lo = {{(ACC_W-BUS_WIDTH+1){1'b1}}, {(BUS_WIDTH-1){1'b0}}};
      if (v > hi)      return {1'b1, hi[BUS_WIDTH-1:0]};
      else if (v < lo) return {1'b1, lo[BUS_WIDTH-1:0]};
      else             return {1'b0, v[BUS_WIDTH-1:0]};
   endfunction

   logic [EW-1:0] elem_w;
   logic          ij_last_w, j_wrap_w, dims_ok_w, res_we;
   logic signed [DATA_WIDTH-1:0]   a_mul, b_mul;
   logic signed [2*DATA_WIDTH-1:0] prod_w;
   logic signed [BUS_WIDTH-1:0]    bias_w;
   logic signed [ACC_W-1:0]        bias_ext, prod_ext, base_w, sum_w;
   logic [BUS_WIDTH:0]             sat_w;

   assign elem_w    = EW'(i_q[IW-1:0]) * EW'(MAX_DIM) + EW'(j_q[IW-1:0]);
   assign j_wrap_w  = (j_q == m_q - ONE_D);
   assign ij_last_w = j_wrap_w && (i_q == n_q - ONE_D);
   assign dims_ok_w = (n_dim_i != '0) && (n_dim_i <= DMAX) && (k_dim_i != '0) && (k_dim_i <= DMAX)
                   && (m_dim_i != '0) && (m_dim_i <= DMAX);

   // MAC datapath: accumulator is preloaded with the sign-extended bias on the first term.
   assign a_mul    = a_q[i_q[IW-1:0]][l_q[IW-1:0]];
   assign b_mul    = b_q[l_q[IW-1:0]][j_q[IW-1:0]];
   assign prod_w   = a_mul * b_mul;
   assign bias_w   = mode_q ? c_q[elem_w] : '0;
   assign bias_ext = {{(ACC_W-BUS_WIDTH){bias_w[BUS_WIDTH-1]}}, bias_w};
   assign prod_ext = {{(ACC_W-2*DATA_WIDTH){prod_w[2*DATA_WIDTH-1]}}, prod_w};
   assign base_w   = (l_q == '0) ? bias_ext : acc_q;
   assign sum_w    = base_w + prod_ext;
   assign sat_w    = saturate(sum_w);

   always_comb begin
      state_d = state_q;  n_d = n_q;  k_d = k_q;  m_d = m_q;
      mode_d = mode_q;    err_d = err_q;  flags_d = flags_q;
      cnt_d = cnt_q;  i_d = i_q;  j_d = j_q;  l_d = l_q;  acc_d = acc_q;
      tag_d = T_NONE;  tidx_d = '0;  res_we = 1'b0;
      bus.rd_en_o = 1'b0;  bus.rd_addr_o = '0;
      bus.wr_en_o = 1'b0;  bus.wr_addr_o = '0;
      unique case (state_q)
         S_IDLE: if (start_i) begin
            if (dims_ok_w) begin
               n_d = n_dim_i;  k_d = k_dim_i;  m_d = m_dim_i;  mode_d = mode_i;
               flags_d = '0;  err_d = 1'b0;
               cnt_d = '0;  i_d = '0;  j_d = '0;  l_d = '0;
               state_d = S_LOAD_A;
            end else begin
               err_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_LOAD_A, S_LOAD_B: begin
            bus.rd_en_o   = 1'b1;
            bus.rd_addr_o = mk_addr((state_q == S_LOAD_A) ? SEL_A : SEL_B, EW'(cnt_q[IW-1:0]));
            tag_d  = (state_q == S_LOAD_A) ? T_A : T_B;
            tidx_d = EW'(cnt_q[IW-1:0]);
            cnt_d  = cnt_q + ONE_D;
            if (state_q == S_LOAD_A && cnt_q == n_q - ONE_D) begin
               cnt_d = '0;  state_d = S_LOAD_B;
            end else if (state_q == S_LOAD_B && cnt_q == k_q - ONE_D) begin
               cnt_d = '0;  state_d = mode_q ? S_LOAD_C : S_DRAIN;
            end
         end
         S_LOAD_C: begin
            bus.rd_en_o   = 1'b1;
            bus.rd_addr_o = mk_addr(SEL_C, elem_w);
            tag_d  = T_C;
            tidx_d = elem_w;
            if (ij_last_w)     begin i_d = '0; j_d = '0; state_d = S_DRAIN; end
            else if (j_wrap_w) begin i_d = i_q + ONE_D; j_d = '0; end
            else               j_d = j_q + ONE_D;
         end
         S_DRAIN: state_d = S_COMPUTE;
         S_COMPUTE: begin
            acc_d = sum_w;
            if (l_q == k_q - ONE_D) begin
               l_d    = '0;
               res_we = 1'b1;
               if (sat_w[BUS_WIDTH]) flags_d[elem_w] = 1'b1;
               if (ij_last_w)     begin i_d = '0; j_d = '0; state_d = S_WRITE; end
               else if (j_wrap_w) begin i_d = i_q + ONE_D; j_d = '0; end
               else               j_d = j_q + ONE_D;
            end else begin
               l_d = l_q + ONE_D;
            end
         end
         S_WRITE: begin
            bus.wr_en_o   = 1'b1;
            bus.wr_addr_o = mk_addr(SEL_C, elem_w);
            if (ij_last_w)     begin i_d = '0; j_d = '0; state_d = S_DONE; end
            else if (j_wrap_w) begin i_d = i_q + ONE_D; j_d = '0; end
            else               j_d = j_q + ONE_D;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;  tag_q <= T_NONE;  tidx_q <= '0;
         n_q <= '0;  k_q <= '0;  m_q <= '0;  mode_q <= 1'b0;  err_q <= 1'b0;
         flags_q <= '0;  cnt_q <= '0;  i_q <= '0;  j_q <= '0;  l_q <= '0;
      end else begin
         state_q <= state_d;  tag_q <= tag_d;  tidx_q <= tidx_d;
         n_q <= n_d;  k_q <= k_d;  m_q <= m_d;  mode_q <= mode_d;  err_q <= err_d;
         flags_q <= flags_d;  cnt_q <= cnt_d;  i_q <= i_d;  j_q <= j_d;  l_q <= l_d;
      end
   end

   // Read data arrives one cycle after its request; the registered tag steers it.
   always_ff @(posedge clk_i) begin
      acc_q <= acc_d;
      unique case (tag_q)
         T_A: for (int e = 0; e < MAX_DIM; e++)
                 a_q[tidx_q[IW-1:0]][e] <= bus.rd_data_i[e*DATA_WIDTH +: DATA_WIDTH];
         T_B: for (int e = 0; e < MAX_DIM; e++)
                 b_q[tidx_q[IW-1:0]][e] <= bus.rd_data_i[e*DATA_WIDTH +: DATA_WIDTH];
         T_C: c_q[tidx_q] <= bus.rd_data_i;
         default: ;
      endcase
      if (res_we) res_q[elem_w] <= sat_w[BUS_WIDTH-1:0];
   end

   assign bus.wr_data_o = bus.wr_en_o ? res_q[elem_w] : '0;
   assign busy_o  = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o  = (state_q == S_DONE);
   assign err_o   = (state_q == S_DONE) && err_q;
   assign flags_o = flags_q;
endmodule

// File: tb/tb_matmul_seq_engine.sv
// Directed bench for matmul_seq_engine with a behavioural scratchpad and a vector table.
module tb_matmul_seq_engine;
  logic clk_i = 1'b0;
  logic rst_i, start_i, mode_i;
  logic [1:0] n_dim_i, k_dim_i, m_dim_i;
  logic busy_o, done_o, err_o;
  logic [3:0] flags_o;
  int checks = 0, failures = 0;

  matmul_seq_engine_if #(.BUS_WIDTH(16), .ADDR_WIDTH(32)) bus ();

  matmul_seq_engine #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i), .bus(bus),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .flags_o(flags_o)
  );

  always #5 clk_i = ~clk_i;

  // Scratchpad: A/B rows at sel 4/8 with row in addr[5], C elements at sel 16 with index in addr[6:5].
  logic [15:0] a_mem [2];
  logic [15:0] b_mem [2];
  logic [15:0] c_mem [4];

  function automatic logic [15:0] rd_lookup(input logic [31:0] a);
    case (a[4:0])
      5'b00100: return a_mem[a[5]];
      5'b01000: return b_mem[a[5]];
      5'b10000: return c_mem[a[6:5]];
      default:  return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk_i) if (bus.rd_en_o) bus.rd_data_i <= rd_lookup(bus.rd_addr_o);

  int n_rd, n_crd, n_ovl, n_bd, n_bad;
  logic [31:0] wa_q [$];
  logic [15:0] wd_q [$];

  always @(negedge clk_i) begin
    if (bus.rd_en_o) begin
      n_rd++;
      if (bus.rd_addr_o[4:0] == 5'b10000) n_crd++;
      if (bus.rd_addr_o[31:7] != '0) n_bad++;
    end
    if (bus.wr_en_o) begin
      wa_q.push_back(bus.wr_addr_o);
      wd_q.push_back(bus.wr_data_o);
    end
    if (bus.rd_en_o && bus.wr_en_o) n_ovl++;
    if (busy_o && done_o) n_bd++;
  end

  task automatic clear_mon();
    n_rd = 0; n_crd = 0; n_ovl = 0; n_bd = 0; n_bad = 0;
    wa_q.delete(); wd_q.delete();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string name;
    logic [1:0] n, k, m;
    bit md;
    logic [15:0] a0, a1, b0, b1;
    logic [63:0] c;      // {c3,c2,c1,c0}
    int nw;
    logic [7:0] we;      // expected element index of write w at [2w +: 2]
    logic [63:0] wd;     // expected data of write w at [16w +: 16]
    logic [3:0] fl;
    bit er;
    int rd, crd, dn;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [1:0] n, k, m, input bit md,
                              input logic [15:0] a0, a1, b0, b1, input logic [63:0] c,
                              input int nw, input logic [7:0] we, input logic [63:0] wd,
                              input logic [3:0] fl, input bit er, input int rd, crd, dn);
    vec_t v;
    v.name = nm; v.n = n; v.k = k; v.m = m; v.md = md;
    v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1; v.c = c;
    v.nw = nw; v.we = we; v.wd = wd; v.fl = fl; v.er = er;
    v.rd = rd; v.crd = crd; v.dn = dn;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input bit poke, output int dcyc, output bit derr);
    a_mem[0] = v.a0; a_mem[1] = v.a1; b_mem[0] = v.b0; b_mem[1] = v.b1;
    for (int e = 0; e < 4; e++) c_mem[e] = v.c[e*16 +: 16];
    clear_mon();
    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = v.n; k_dim_i = v.k; m_dim_i = v.m; mode_i = v.md;
    @(posedge clk_i);
    dcyc = -1; derr = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_i);
      if (poke && (c == 5 || c == 10)) begin
        start_i = 1'b1; n_dim_i = 2'd1; k_dim_i = 2'd1; m_dim_i = 2'd1; mode_i = 1'b0;
      end else start_i = 1'b0;
      if (done_o) begin dcyc = c; derr = err_o; break; end
    end
    start_i = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input int dcyc, input bit derr);
    chk({v.name, " done_cycle"}, 64'(dcyc), 64'(v.dn));
    chk({v.name, " err"}, 64'(derr), 64'(v.er));
    chk({v.name, " flags"}, 64'(flags_o), 64'(v.fl));
    chk({v.name, " write_count"}, 64'(wa_q.size()), 64'(v.nw));
    for (int w = 0; w < v.nw; w++) begin
      chk({v.name, $sformatf(" write%0d_addr", w)},
          64'((w < wa_q.size()) ? wa_q[w] : 32'hFFFF_FFFF), 64'({v.we[w*2 +: 2], 5'b10000}));
      chk({v.name, $sformatf(" write%0d_data", w)},
          64'((w < wd_q.size()) ? wd_q[w] : 16'hBEEF), 64'(v.wd[w*16 +: 16]));
    end
    chk({v.name, " read_count"}, 64'(n_rd), 64'(v.rd));
    chk({v.name, " c_read_count"}, 64'(n_crd), 64'(v.crd));
    chk({v.name, " read_addr_upper_bits"}, 64'(n_bad), 64'(0));
    chk({v.name, " rd_wr_overlap"}, 64'(n_ovl), 64'(0));
    chk({v.name, " busy_with_done"}, 64'(n_bd), 64'(0));
  endtask

  vec_t vecs [7];
  int dcyc;
  bit derr;
  int dn_at [2];
  int ndone;

  initial begin
    vecs[0] = mk("ident", 2'd2, 2'd2, 2'd2, 1'b0, 16'h0001, 16'h0100, 16'hFC03, 16'h0605, 64'h0,
                 4, 8'hE4, 64'h0006_0005_FFFC_0003, 4'b0000, 1'b0, 4, 0, 18);
    vecs[1] = mk("bias", 2'd2, 2'd2, 2'd2, 1'b1, 16'h0001, 16'h0100, 16'hFC03, 16'h0605,
                 64'h0028_001E_0014_000A, 4, 8'hE4, 64'h002E_0023_0010_000D, 4'b0000, 1'b0, 8, 4, 22);
    vecs[2] = mk("possat", 2'd2, 2'd2, 2'd2, 1'b1, 16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F7F,
                 64'h03E8_03E8_03E8_03E8, 4, 8'hE4, 64'h7FFF_7FFF_7FFF_7FFF, 4'b1111, 1'b0, 8, 4, 22);
    vecs[3] = mk("negsat", 2'd1, 2'd2, 2'd1, 1'b1, 16'h8080, 16'h0000, 16'h557F, 16'hAA7F,
                 64'h0000_0000_0000_FC18, 1, 8'h00, 64'h8000, 4'b0001, 1'b0, 4, 1, 9);
    vecs[4] = mk("illegal_k0", 2'd2, 2'd0, 2'd2, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 64'h0,
                 0, 8'h00, 64'h0, 4'b0001, 1'b1, 0, 0, 1);
    vecs[5] = mk("illegal_m3", 2'd2, 2'd2, 2'd3, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 64'h0,
                 0, 8'h00, 64'h0, 4'b0001, 1'b1, 0, 0, 1);
    vecs[6] = mk("rect_nobias", 2'd2, 2'd1, 2'd1, 1'b0, 16'h3305, 16'h77FD, 16'h1107, 16'h0000,
                 64'h1111_1111_1111_1111, 2, 8'h08, 64'hFFEB_0023, 4'b0000, 1'b0, 3, 0, 9);

    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0;
    n_dim_i = 2'd0; k_dim_i = 2'd0; m_dim_i = 2'd0;
    #1;
    chk("reset busy", 64'(busy_o), 64'(0));
    chk("reset done", 64'(done_o), 64'(0));
    chk("reset err", 64'(err_o), 64'(0));
    chk("reset flags", 64'(flags_o), 64'(0));
    chk("reset rd_en", 64'(bus.rd_en_o), 64'(0));
    chk("reset wr_en", 64'(bus.wr_en_o), 64'(0));
    chk("reset wr_data", 64'(bus.wr_data_o), 64'(0));
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    for (int t = 0; t < 7; t++) begin
      run_vec(vecs[t], 1'b0, dcyc, derr);
      check_vec(vecs[t], dcyc, derr);
      repeat (2) @(negedge clk_i);
    end

    // Start held high across DONE is accepted again in the following IDLE cycle.
    a_mem[0] = 16'h0002; b_mem[0] = 16'h0003;
    clear_mon();
    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = 2'd1; k_dim_i = 2'd1; m_dim_i = 2'd1; mode_i = 1'b0;
    @(posedge clk_i);
    ndone = 0; dn_at[0] = -1; dn_at[1] = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      if (done_o) begin dn_at[ndone] = c; ndone++; end
      if (ndone == 2) break;
    end
    start_i = 1'b0;
    chk("held_start first_done", 64'(dn_at[0]), 64'(6));
    chk("held_start second_done", 64'(dn_at[1]), 64'(13));
    chk("held_start write_count", 64'(wa_q.size()), 64'(2));
    chk("held_start write1_data", 64'((wd_q.size() > 1) ? wd_q[1] : 16'hBEEF), 64'(6));
    repeat (3) @(negedge clk_i);

    // Reset in the middle of COMPUTE after two saturated elements.
    a_mem[0] = 16'h7F7F; a_mem[1] = 16'h7F7F; b_mem[0] = 16'h7F7F; b_mem[1] = 16'h7F7F;
    for (int e = 0; e < 4; e++) c_mem[e] = 16'h03E8;
    clear_mon();
    @(negedge clk_i);
    start_i = 1'b1; n_dim_i = 2'd2; k_dim_i = 2'd2; m_dim_i = 2'd2; mode_i = 1'b1;
    @(posedge clk_i);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    chk("midrst busy_before", 64'(busy_o), 64'(1));
    chk("midrst flags_before", 64'(flags_o), 64'(4'b0011));
    rst_i = 1'b1;
    #1;
    chk("midrst busy", 64'(busy_o), 64'(0));
    chk("midrst done", 64'(done_o), 64'(0));
    chk("midrst flags", 64'(flags_o), 64'(0));
    chk("midrst rd_addr", 64'(bus.rd_addr_o), 64'(0));
    chk("midrst wr_en", 64'(bus.wr_en_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_mon();
    repeat (30) @(negedge clk_i);
    chk("midrst writes_after", 64'(wa_q.size()), 64'(0));
    chk("midrst reads_after", 64'(n_rd), 64'(0));

    // Normal run after reset, with start pulses and dimension changes while busy.
    run_vec(vecs[1], 1'b1, dcyc, derr);
    check_vec(vecs[1], dcyc, derr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
